corelet_ctrl: RTL

- Sequencing FSM for one corelet tile: weight-stationary convolution over cfg_nkij kernel positions, each with cfg_len activation vectors.
- Per kernel position, in order: fetch weights from input SRAM into L0, shift them into the PE array, fetch and stream activations, drain OFIFO, and write back through the SFP with accumulation into psum SRAM.
- Sits between the top-level testbench/host and the corelet plus its two SRAMs. Drives every corelet control input.

---
 rtl/corelet_ctrl_if.sv | 36 +++
 rtl/corelet_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/corelet_ctrl_if.sv
// Control bundle between the corelet sequencer and its host, corelet datapath and SRAMs.
// The master modport is the sequencer side; the slave modport is the host/datapath side.
interface corelet_ctrl_if #(
    parameter int ADDR_BW = 11
) ();
    logic               start;
    logic [4:0]         cfg_len;
    logic [3:0]         cfg_nkij;
    logic               busy;
    logic               done;
    logic               xmem_cen;
    logic [ADDR_BW-1:0] xmem_addr;
    logic               pmem_cen;
    logic               pmem_wen;
    logic [ADDR_BW-1:0] pmem_addr;
    logic               l0_wr;
    logic               l0_rd;
    logic               l0_ready;
    logic [2:0]         inst_w;
    logic               ofifo_rd;
    logic               ofifo_valid;
    logic               sfp_acc_i;
    logic               sfp_psum_bypass;

    modport master (
        input  start, cfg_len, cfg_nkij, l0_ready, ofifo_valid,
        output busy, done, xmem_cen, xmem_addr, pmem_cen, pmem_wen, pmem_addr,
               l0_wr, l0_rd, inst_w, ofifo_rd, sfp_acc_i, sfp_psum_bypass
    );

    modport slave (
        output start, cfg_len, cfg_nkij, l0_ready, ofifo_valid,
        input  busy, done, xmem_cen, xmem_addr, pmem_cen, pmem_wen, pmem_addr,
               l0_wr, l0_rd, inst_w, ofifo_rd, sfp_acc_i, sfp_psum_bypass
    );
endinterface

// File: rtl/corelet_ctrl.sv
// Sequencer for one weight-stationary corelet tile: per kernel position it fills L0 with
// weights, loads the PE array, streams activations and accumulates the results into psum SRAM.
module corelet_ctrl #(
    parameter int ROW      = 8,
    parameter int COL      = 8,
    parameter int L0_DEPTH = 16,
    parameter int ADDR_BW  = 11,
    parameter int W_BASE   = 1024
) (
    input  logic           i_clk,
    input  logic           i_reset,
    corelet_ctrl_if.master io_bus
);

    localparam int CNT_MAX = (L0_DEPTH > ROW + COL) ? L0_DEPTH : ROW + COL;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_FILL,
        S_W_LOAD,
        S_W_WAIT,
        S_A_FILL,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        D_WAIT,
        D_READ,
        D_POP,
        D_WRITE
    } drain_t;

    state_t             r_state;
    drain_t             r_step;
    logic [4:0]         r_len;
    logic [3:0]         r_nkij;
    logic [3:0]         r_k;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_xmemCen;
    logic [ADDR_BW-1:0] r_xmemAddr;
    logic               r_pmemCen;
    logic               r_pmemWen;
    logic [ADDR_BW-1:0] r_pmemAddr;
    logic               r_l0Wr;
    logic               r_l0Rd;
    logic [1:0]         r_inst;
    logic               r_ofifoRd;
    logic               r_sfpAcc;

    logic               w_isWFill;
    logic [CNT_W-1:0]   w_fillTarget;
    logic [ADDR_BW-1:0] w_fillAddr;
    logic [CNT_W-1:0]   w_lenLast;
    logic [3:0]         w_kNext;

    assign w_isWFill    = (r_state == S_W_FILL);
    assign w_fillTarget = w_isWFill ? CNT_W'(COL) : CNT_W'(r_len);
    assign w_fillAddr   = w_isWFill ? ADDR_BW'(W_BASE + int'(r_k) * COL + int'(r_cnt))
                                    : ADDR_BW'(r_cnt);
    assign w_lenLast    = CNT_W'(r_len) - CNT_W'(1);
    assign w_kNext      = r_k + 4'd1;

    // r_cnt is shared: reads issued while filling, cycles in LOAD/WAIT/EXEC, output index in DRAIN.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_step     <= D_WAIT;
            r_len      <= '0;
            r_nkij     <= '0;
            r_k        <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_xmemCen  <= 1'b1;
            r_xmemAddr <= '0;
            r_pmemCen  <= 1'b1;
            r_pmemWen  <= 1'b1;
            r_pmemAddr <= '0;
            r_l0Wr     <= 1'b0;
            r_l0Rd     <= 1'b0;
            r_inst     <= 2'b00;
            r_ofifoRd  <= 1'b0;
            r_sfpAcc   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_len  <= io_bus.cfg_len;
                        r_nkij <= io_bus.cfg_nkij;
                        r_k    <= '0;
                        r_cnt  <= '0;
                        r_step <= D_WAIT;
                        r_busy <= 1'b1;
                        if (io_bus.cfg_len == 5'd0 || io_bus.cfg_nkij == 4'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_W_FILL;
                        end
                    end
                end

                // SRAM data arrives a cycle after the read, so l0_wr trails xmem_cen by one cycle.
                S_W_FILL, S_A_FILL: begin
                    r_l0Wr <= !r_xmemCen;
                    if (r_cnt == w_fillTarget && r_xmemCen) begin
                        r_cnt  <= '0;
                        r_l0Rd <= 1'b1;
                        if (w_isWFill) begin
                            r_inst  <= 2'b01;
                            r_state <= S_W_LOAD;
                        end else begin
                            r_inst  <= 2'b10;
                            r_state <= S_EXEC;
                        end
                    end else if (r_cnt != w_fillTarget && io_bus.l0_ready) begin
                        r_xmemCen  <= 1'b0;
                        r_xmemAddr <= w_fillAddr;
                        r_cnt      <= r_cnt + CNT_W'(1);
                    end else begin
                        r_xmemCen <= 1'b1;
                    end
                end

                S_W_LOAD: begin
                    if (r_cnt == CNT_W'(COL - 1)) begin
                        r_cnt   <= '0;
                        r_l0Rd  <= 1'b0;
                        r_inst  <= 2'b00;
                        r_state <= S_W_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_W_WAIT: begin
                    if (r_cnt == CNT_W'(ROW + COL - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_A_FILL;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_EXEC: begin
                    if (r_cnt == w_lenLast) begin
                        r_cnt   <= '0;
                        r_l0Rd  <= 1'b0;
                        r_inst  <= 2'b00;
                        r_step  <= D_WAIT;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                // Each output: optional psum read, OFIFO pop into the SFP, then psum write-back.
                S_DRAIN: begin
                    case (r_step)
                        D_WAIT: begin
                            if (io_bus.ofifo_valid) begin
                                r_step <= D_READ;
                                if (r_k != 4'd0) begin
                                    r_pmemCen  <= 1'b0;
                                    r_pmemWen  <= 1'b1;
                                    r_pmemAddr <= ADDR_BW'(r_cnt);
                                end
                            end
                        end
                        D_READ: begin
                            r_pmemCen <= 1'b1;
                            r_ofifoRd <= 1'b1;
                            r_sfpAcc  <= (r_k != 4'd0);
                            r_step    <= D_POP;
                        end
                        D_POP: begin
                            r_ofifoRd  <= 1'b0;
                            r_sfpAcc   <= 1'b0;
                            r_pmemCen  <= 1'b0;
                            r_pmemWen  <= 1'b0;
                            r_pmemAddr <= ADDR_BW'(r_cnt);
                            r_step     <= D_WRITE;
                        end
                        default: begin
                            r_pmemCen <= 1'b1;
                            r_pmemWen <= 1'b1;
                            r_step    <= D_WAIT;
                            if (r_cnt == w_lenLast) begin
                                r_cnt <= '0;
                                r_k   <= w_kNext;
                                if (w_kNext == r_nkij) begin
                                    r_state <= S_DONE;
                                end else begin
                                    r_state <= S_W_FILL;
                                end
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    endcase
                end

                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.busy            = r_busy;
    assign io_bus.done            = r_done;
    assign io_bus.xmem_cen        = r_xmemCen;
    assign io_bus.xmem_addr       = r_xmemAddr;
    assign io_bus.pmem_cen        = r_pmemCen;
    assign io_bus.pmem_wen        = r_pmemWen;
    assign io_bus.pmem_addr       = r_pmemAddr;
    assign io_bus.l0_wr           = r_l0Wr;
    assign io_bus.l0_rd           = r_l0Rd;
    assign io_bus.inst_w          = {1'b0, r_inst};
    assign io_bus.ofifo_rd        = r_ofifoRd;
    assign io_bus.sfp_acc_i       = r_sfpAcc;
    assign io_bus.sfp_psum_bypass = 1'b0;

endmodule
